// File: rtl/sysarray_pkg.sv
// rtl/sysarray_pkg.sv - shared state enum, flush length and saturating-add helper for sysarray_mm
package sysarray_pkg;

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

  function automatic int flush_len(input int dim);
    return 2 * dim - 1;
  endfunction

  // Returns {positive overflow, negative overflow} from the sign bits of both addends and the sum.
  function automatic logic [1:0] sat_dir(input logic sa, input logic sb, input logic ss);
    return {~sa & ~sb & ss, sa & sb & ~ss};
  endfunction

endpackage

// File: rtl/sysarray_pe.sv
// rtl/sysarray_pe.sv - one MAC cell with operand pass-through registers; SYSARRAY_SAT_EN selects saturating accumulation
module sysarray_pe
  import sysarray_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 en,
  input  logic signed [DW-1:0] a_in,
  input  logic signed [DW-1:0] b_in,
  output logic signed [DW-1:0] a_out,
  output logic signed [DW-1:0] b_out,
  output logic signed [AW-1:0] acc
);

  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   ext;
  logic signed [AW-1:0]   sum;
  logic signed [AW-1:0]   acc_next;

  assign prod = (2*DW)'(a_in) * (2*DW)'(b_in);
  assign ext  = AW'(prod);
  assign sum  = acc + ext;

`ifdef SYSARRAY_SAT_EN
  logic [1:0] dir;
  assign dir      = sat_dir(acc[AW-1], ext[AW-1], sum[AW-1]);
  assign acc_next = dir[1] ? {1'b0, {(AW-1){1'b1}}} :
                    dir[0] ? {1'b1, {(AW-1){1'b0}}} : sum;
`else
  assign acc_next = sum;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_out <= '0;
      b_out <= '0;
      acc   <= '0;
    end else begin
      a_out <= a_in;
      b_out <= b_in;
      if (clr)
        acc <= '0;
      else if (en)
        acc <= acc_next;
    end
  end

endmodule

// File: rtl/sysarray_mm.sv
// rtl/sysarray_mm.sv - DIM x DIM output-stationary systolic matrix multiplier; optional SYSARRAY_SAT_EN
module sysarray_mm
  import sysarray_pkg::*;
#(
  parameter int DIM = 4,
  parameter int DW  = 32,
  parameter int AW  = 64,
  parameter int KW  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [KW-1:0]            k_len,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DIM*DW-1:0]        a_col,
  input  logic [DIM*DW-1:0]        b_row,
  output logic                     busy,
  output logic                     out_valid,
  output logic [$clog2(DIM)-1:0]   out_row_idx,
  output logic [DIM*AW-1:0]        out_row,
  output logic                     done
);

  localparam int RW = $clog2(DIM);
  localparam int FW = $clog2(2*DIM);

  state_t         state;
  logic [KW-1:0]  k_reg;
  logic [KW-1:0]  beat_cnt;
  logic [FW-1:0]  flush_cnt;
  logic [RW-1:0]  drain_cnt;

  logic accept;
  logic clr;
  logic en;

  assign accept = in_valid & in_ready;
  assign clr    = (state == IDLE) & start;
  assign en     = (state == LOAD) | (state == FLUSH);

  logic signed [DW-1:0] a_edge [DIM];
  logic signed [DW-1:0] b_edge [DIM];
  logic signed [DW-1:0] a_pass [DIM][DIM];
  logic signed [DW-1:0] b_pass [DIM][DIM];
  logic signed [AW-1:0] acc    [DIM][DIM];
  logic [DIM-1:0]       unused_a;
  logic [DIM-1:0]       unused_b;

  // Lane i carries i+1 stages so beat k meets PE(i,j) exactly i+j cycles after acceptance.
  for (genvar i = 0; i < DIM; i++) begin : g_skew
    logic signed [DW-1:0] ask [i+1];
    logic signed [DW-1:0] bsk [i+1];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int d = 0; d <= i; d++) begin
          ask[d] <= '0;
          bsk[d] <= '0;
        end
      end else begin
        ask[0] <= accept ? a_col[i*DW +: DW] : '0;
        bsk[0] <= accept ? b_row[i*DW +: DW] : '0;
        for (int d = 1; d <= i; d++) begin
          ask[d] <= ask[d-1];
          bsk[d] <= bsk[d-1];
        end
      end
    end

    assign a_edge[i]   = ask[i];
    assign b_edge[i]   = bsk[i];
    assign unused_a[i] = ^a_pass[i][DIM-1];
    assign unused_b[i] = ^b_pass[DIM-1][i];
  end

  for (genvar i = 0; i < DIM; i++) begin : g_row
    for (genvar j = 0; j < DIM; j++) begin : g_col
      logic signed [DW-1:0] a_src;
      logic signed [DW-1:0] b_src;

      if (j == 0) begin : g_aw
        assign a_src = a_edge[i];
      end else begin : g_ai
        assign a_src = a_pass[i][j-1];
      end

      if (i == 0) begin : g_bn
        assign b_src = b_edge[j];
      end else begin : g_bi
        assign b_src = b_pass[i-1][j];
      end

      sysarray_pe #(
        .DW(DW),
        .AW(AW)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .en    (en),
        .a_in  (a_src),
        .b_in  (b_src),
        .a_out (a_pass[i][j]),
        .b_out (b_pass[i][j]),
        .acc   (acc[i][j])
      );
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      k_reg       <= '0;
      beat_cnt    <= '0;
      flush_cnt   <= '0;
      drain_cnt   <= '0;
      in_ready    <= 1'b0;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      out_row_idx <= '0;
      out_row     <= '0;
      done        <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      done      <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            k_reg     <= k_len;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            busy      <= 1'b1;
            if (k_len == '0) begin
              state <= FLUSH;
            end else begin
              state    <= LOAD;
              in_ready <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            beat_cnt <= beat_cnt + 1'b1;
            if (beat_cnt == k_reg - 1'b1) begin
              state    <= FLUSH;
              in_ready <= 1'b0;
            end
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt + 1'b1;
          if (flush_cnt == FW'(flush_len(DIM) - 1)) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end
        end
        DRAIN: begin
          out_valid   <= 1'b1;
          out_row_idx <= drain_cnt;
          for (int j = 0; j < DIM; j++)
            out_row[j*AW +: AW] <= acc[drain_cnt][j];
          drain_cnt <= drain_cnt + 1'b1;
          if (drain_cnt == RW'(DIM - 1)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sysarray_mm.sv
// tb/tb_sysarray_mm.sv - scoreboard bench for sysarray_mm against a plain-arithmetic matrix model
module tb_sysarray_mm;

  localparam int DIM  = 4;
  localparam int DW   = 8;
  localparam int AW   = 16;
  localparam int KW   = 8;
  localparam int RW   = $clog2(DIM);
  localparam int KMAX = 16;
  localparam longint MAXV = (64'sd1 <<< (AW-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (AW-1));

  typedef struct {
    logic [DIM*AW-1:0] row;
    int                idx;
    bit                last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [KW-1:0]     k_len = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DIM*DW-1:0] a_col = '0;
  logic [DIM*DW-1:0] b_row = '0;
  logic              busy;
  logic              out_valid;
  logic [RW-1:0]     out_row_idx;
  logic [DIM*AW-1:0] out_row;
  logic              done;

  int     checks = 0;
  int     failures = 0;
  int     cyc = 0;
  int     done_cnt = 0;
  int     done_cyc = 0;
  bit     job_active = 1'b0;
  bit     busy_bad = 1'b0;
  exp_t   exp_q[$];
  int     ma [DIM][KMAX];
  int     mb [KMAX][DIM];

  sysarray_mm #(.DIM(DIM), .DW(DW), .AW(AW), .KW(KW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .k_len       (k_len),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a_col       (a_col),
    .b_row       (b_row),
    .busy        (busy),
    .out_valid   (out_valid),
    .out_row_idx (out_row_idx),
    .out_row     (out_row),
    .done        (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic longint acc_step(input longint acc, input longint p);
    longint t;
    logic [AW-1:0] w;
    t = acc + p;
`ifdef SYSARRAY_SAT_EN
    if (t > MAXV) t = MAXV;
    if (t < MINV) t = MINV;
`else
    w = t[AW-1:0];
    t = longint'($signed(w));
`endif
    return t;
  endfunction

  task automatic push_expected(input int k);
    exp_t e;
    longint acc;
    for (int r = 0; r < DIM; r++) begin
      e.row = '0;
      for (int j = 0; j < DIM; j++) begin
        acc = 0;
        for (int kk = 0; kk < k; kk++)
          acc = acc_step(acc, longint'(ma[r][kk]) * longint'(mb[kk][j]));
        e.row[j*AW +: AW] = AW'(acc);
      end
      e.idx  = r;
      e.last = (r == DIM - 1);
      exp_q.push_back(e);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (job_active && !busy && !done) busy_bad = 1'b1;
      if (done && !out_valid) chk("done_without_valid", 1, 0);
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_row", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk($sformatf("row%0d_data", e.idx), out_row, e.row);
          chk($sformatf("row%0d_idx", e.idx), out_row_idx, e.idx);
          chk($sformatf("row%0d_done", e.idx), done, e.last);
        end
        if (done) begin
          done_cyc = cyc;
          done_cnt++;
        end
      end
    end
  end

  task automatic clear_mats();
    for (int i = 0; i < DIM; i++)
      for (int kk = 0; kk < KMAX; kk++) begin
        ma[i][kk] = 0;
        mb[kk][i] = 0;
      end
  endtask

  task automatic rand_mats(input int k);
    clear_mats();
    for (int i = 0; i < DIM; i++)
      for (int kk = 0; kk < k; kk++) begin
        ma[i][kk] = int'($urandom_range(0, 255)) - 128;
        mb[kk][i] = int'($urandom_range(0, 255)) - 128;
      end
  endtask

  task automatic run_job(input string name, input int k, input int gap, input bit mid_start, input bit abort);
    int s;
    int d0;
    int guard;
    d0 = done_cnt;
    if (!abort) push_expected(k);
    start = 1'b1;
    k_len = KW'(k);
    @(posedge clk); #1;
    s = cyc;
    job_active = 1'b1;
    busy_bad = 1'b0;
    start = 1'b0;
    for (int b = 0; b < k; b++) begin
      if (b == 1 && gap > 0) begin
        in_valid = 1'b0;
        repeat (gap) @(posedge clk);
        #1;
      end
      for (int i = 0; i < DIM; i++) begin
        a_col[i*DW +: DW] = DW'(ma[i][b]);
        b_row[i*DW +: DW] = DW'(mb[b][i]);
      end
      in_valid = 1'b1;
      if (b == 1 && mid_start) begin
        start = 1'b1;
        k_len = KW'(3);
      end
      guard = 0;
      while (!in_ready && guard < 50) begin
        @(posedge clk); #1;
        guard++;
      end
      if (guard >= 50) chk({name, "_in_ready_timeout"}, 0, 1);
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_valid = 1'b0;
    a_col = '0;
    b_row = '0;
    if (abort) begin
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk({name, "_rst_out_valid"}, out_valid, 0);
      chk({name, "_rst_done"}, done, 0);
      chk({name, "_rst_busy"}, busy, 0);
      chk({name, "_rst_out_row"}, out_row, 0);
      job_active = 1'b0;
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b0;
    end else begin
      guard = 0;
      while (done_cnt == d0 && guard < 300) begin
        @(negedge clk); #1;
        guard++;
      end
      job_active = 1'b0;
      if (guard >= 300) chk({name, "_done_timeout"}, 0, 1);
      else chk({name, "_done_latency"}, done_cyc - s, k + ((k > 1) ? gap : 0) + 3*DIM - 1);
      chk({name, "_busy_held"}, busy_bad, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_in_ready", in_ready, 0);
    chk("reset_busy", busy, 0);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_done", done, 0);
    chk("reset_out_row", {out_row, out_row_idx}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    clear_mats();
    ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
    mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
    run_job("ex2x2", 2, 0, 1'b0, 1'b0);
    run_job("ex2x2_gap", 2, 3, 1'b0, 1'b0);

    rand_mats(5);
    ma[0][0] = -128; mb[0][0] = -128; ma[3][4] = -128; mb[4][3] = -128;
    run_job("signed_k5", 5, 0, 1'b1, 1'b0);

    run_job("k_zero", 0, 0, 1'b0, 1'b0);

    rand_mats(4);
    run_job("abort_flush", 4, 0, 1'b0, 1'b1);
    clear_mats();
    for (int i = 0; i < DIM; i++) begin
      ma[i][i] = 1;
      for (int j = 0; j < DIM; j++) mb[i][j] = i*DIM + j + 1;
    end
    run_job("identity", DIM, 0, 1'b0, 1'b0);

    clear_mats();
    for (int i = 0; i < DIM; i++)
      for (int kk = 0; kk < 3; kk++) begin
        ma[i][kk] = 127;
        mb[kk][i] = 127;
      end
    run_job("sat_wrap", 3, 0, 1'b0, 1'b0);

    for (int n = 0; n < 6; n++) begin
      int k;
      k = int'($urandom_range(1, 8));
      rand_mats(k);
      run_job($sformatf("rand%0d", n), k, int'($urandom_range(0, 3)), 1'b0, 1'b0);
    end

    repeat (3) @(posedge clk);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sysarray_mm.md
Name: sysarray_mm

Overview:
- Parametrised DIM x DIM output-stationary systolic matrix multiplier computing C = A x B, with A of size DIM x K and B of size K x DIM.
- Successor to the fixed 2x2 sysarray: input skewing, beat counting and result drain now live inside the block instead of being sequenced by the driver.
- Sits between the operand fetch logic and the result writeback.
- Adds a start/done handshake, runtime inner dimension K, an input valid/ready flow and row-serial result output.

Parameters:
- DIM, 4, array rows/cols (>=2).
- DW, 32, signed operand width.
- AW, 64, signed accumulator width (>= 2*DW).
- KW, 8, width of k_len.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  begin a job; sampled only in IDLE.
- k_len  in  KW  inner dimension K; latched on accepted start.
- in_valid  in  1  beat present on a_col/b_row.
- in_ready  out  1  high only in LOAD.
- a_col  in  DIM*DW  column k of A; element i at bits [i*DW +: DW].
- b_row  in  DIM*DW  row k of B; element j at bits [j*DW +: DW].
- busy  out  1  high whenever state != IDLE.
- out_valid  out  1  result row present.
- out_row_idx  out  $clog2(DIM)  row index r of C.
- out_row  out  DIM*AW  C[r][j] at bits [j*AW +: AW].
- done  out  1  one-cycle pulse with the last result row.

Behaviour:
- Reset (async, any state): state=IDLE; all accumulators, skew registers and PE pass registers cleared; in_ready, busy, out_valid and done are 0; out_row and out_row_idx are 0.
- FSM states: IDLE, LOAD, FLUSH, DRAIN.
  - IDLE -> LOAD on start. Latch k_len, clear all accumulators and the beat counter.
  - k_len=0: IDLE -> FLUSH directly, so the job outputs all-zero rows.
  - LOAD: a beat is accepted when in_valid && in_ready. beat_cnt increments on each accepted beat. On acceptance of beat K-1, go to FLUSH.
  - FLUSH: lasts exactly 2*DIM-1 cycles (counter), then DRAIN.
  - DRAIN: exactly DIM cycles with out_valid=1, out_row_idx=0..DIM-1 in order. done=1 together with row DIM-1, then IDLE.
- start while busy is ignored; a new start can be accepted the cycle after done.
- Skew: row i of A is delayed i cycles; column j of B is delayed j cycles.
  - A values move right one PE per cycle; B values move down one PE per cycle.
  - Beat k reaches PE(i,j) i+j cycles after acceptance.
- Bubbles: in LOAD cycles without acceptance, zeros are injected into the skew lines. Operands are consumed only on acceptance, and no beat is lost or duplicated.
- PE: acc <= acc + sext(a)*sext(b).
  - Product width is 2*DW, sign-extended to AW.
  - Default is two's-complement wrap modulo 2^AW.
- Outputs are registered. out_row holds its last value when out_valid=0.
- Latency: start accepted at edge 0 with continuous in_valid gives beats at edges 1..K, FLUSH at edges K+1..K+2*DIM-1, DRAIN at edges K+2*DIM..K+3*DIM-1. done is at edge K+3*DIM-1.
- Reset mid-job aborts with no output and no done. The next job after reset is unaffected.

Optional Feature:
- Macro: SYSARRAY_SAT_EN.
- Defined: each accumulation saturates to [-2^(AW-1), 2^(AW-1)-1]. A saturated PE stays clamped unless a later product brings it back in range (clamp applied on every add).
- Undefined: wrap-around modulo 2^AW, and no saturation logic is generated.

Decomposition:
- Package sysarray_pkg holds:
  - the state enum (IDLE, LOAD, FLUSH, DRAIN);
  - localparam function flush_len(DIM)=2*DIM-1;
  - the saturating-add helper function, used under SYSARRAY_SAT_EN.
- Sub-module sysarray_pe: one MAC cell with a_in/b_in pass-through registers, an accumulator, a clear input and an enable input. It is instantiated DIM*DIM times by generate.

Test Plan:
- DIM=2, A=[[1,2],[3,4]], B=[[5,6],[7,8]], K=2, continuous valid:
  - beat0 a_col={3,1}, b_row={6,5}; beat1 a_col={4,2}, b_row={8,7};
  - expect row0 {22,19} and row1 {50,43} (MSB..LSB);
  - done at edge 7 after start.
- Same job with in_valid low for 3 cycles between beats: identical results, and done delayed by exactly 3 cycles.
- DIM=4, K=5, signed operands including -2^(DW-1): results match a golden model. start pulsed mid-job is ignored and busy stays high throughout.
- k_len=0: four all-zero rows, and done at edge 3*DIM-1.
- rst asserted during FLUSH:
  - outputs go to 0 immediately; no out_valid and no done;
  - a following job with A=I (identity), B=[1..16] returns B exactly.
- DW=8, AW=16, K=3, every product 127*127:
  - without SYSARRAY_SAT_EN, result=48387 mod 2^16 interpreted as signed = -17149;
  - with the macro defined, result=32767.
